// File: rtl/tx_arbiter_if.sv
// 8-bit AXI-stream link: tdata/tvalid/tlast flow downstream, tready flows back.
interface tx_arbiter_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin, frame-atomic ARP/UDP -> MAC stream arbiter with inter-frame gap and length cap.
// Grant one cycle after request, zero-latency pass-through; mac tready stalls the owner in place.
module tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int MAX_FRAME_LEN = 1514
) (
    input  logic         clk,
    input  logic         reset,
    tx_arbiter_if.slave  arp_axis,
    tx_arbiter_if.slave  udp_axis,
    tx_arbiter_if.master mac_axis,
    output logic [1:0]   grant_out,
    output logic         trunc_err_out
);
    typedef enum logic [2:0] {IDLE, SEND_ARP, SEND_UDP, DROP, GAP} state_t;

    localparam logic [15:0] LAST_BEAT  = 16'(MAX_FRAME_LEN - 1);
    localparam logic [15:0] GAP_LAST   = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    localparam state_t      FRAME_DONE = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t      state_q, state_d;
    logic        own_q, own_d;     // current/most recent owner: 1 = UDP
    logic        last_q, last_d;   // owner of the last completed frame: 1 = UDP
    logic [15:0] beat_q, beat_d;
    logic [15:0] gap_q, gap_d;

    logic [7:0]  src_dat;
    logic        src_vld;
    logic        src_lst;
    logic        src_rdy;

    always_comb begin
        src_dat = own_q ? udp_axis.tdata  : arp_axis.tdata;
        src_vld = own_q ? udp_axis.tvalid : arp_axis.tvalid;
        src_lst = own_q ? udp_axis.tlast  : arp_axis.tlast;
    end

    always_comb begin
        state_d          = state_q;
        own_d            = own_q;
        last_d           = last_q;
        beat_d           = beat_q;
        gap_d            = gap_q;
        src_rdy          = 1'b0;
        grant_out        = 2'b00;
        trunc_err_out    = 1'b0;
        mac_axis.tdata   = 8'h00;
        mac_axis.tvalid  = 1'b0;
        mac_axis.tlast   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arp_axis.tvalid || udp_axis.tvalid) begin
                    // On a tie the source that did not own the last frame wins.
                    own_d   = udp_axis.tvalid && (!arp_axis.tvalid || !last_q);
                    state_d = own_d ? SEND_UDP : SEND_ARP;
                end
            end
            SEND_ARP, SEND_UDP: begin
                grant_out       = own_q ? 2'b10 : 2'b01;
                mac_axis.tdata  = src_dat;
                mac_axis.tvalid = src_vld;
                mac_axis.tlast  = src_lst;
                src_rdy         = mac_axis.tready;
                if (src_vld && mac_axis.tready) begin
                    if (src_lst) begin
                        beat_d  = 16'd0;
                        last_d  = own_q;
                        gap_d   = 16'd0;
                        state_d = FRAME_DONE;
                    end else if (beat_q == LAST_BEAT) begin
                        mac_axis.tlast = 1'b1;
                        trunc_err_out  = 1'b1;
                        beat_d         = beat_q + 16'd1;
                        state_d        = DROP;
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            DROP: begin
                grant_out = own_q ? 2'b10 : 2'b01;
                src_rdy   = 1'b1;
                if (src_vld && src_lst) begin
                    beat_d  = 16'd0;
                    last_d  = own_q;
                    gap_d   = 16'd0;
                    state_d = FRAME_DONE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        arp_axis.tready = src_rdy && !own_q;
        udp_axis.tready = src_rdy &&  own_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= 16'd0;
            gap_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: three instances (default, 8-beat cap, zero gap) checked by a
// per-source scoreboard of expected MAC beats plus directed grant/gap/reset checks.
module tb_tx_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    tx_arbiter_if a0 (), u0 (), m0 ();
    tx_arbiter_if a1 (), u1 (), m1 ();
    tx_arbiter_if a2 (), u2 (), m2 ();
    logic [1:0] g0, g1, g2;
    logic       t0, t1, t2;

    tx_arbiter #(.IFG_CYCLES(12), .MAX_FRAME_LEN(1514)) dut0 (
        .clk(clk), .reset(reset), .arp_axis(a0), .udp_axis(u0), .mac_axis(m0),
        .grant_out(g0), .trunc_err_out(t0));
    tx_arbiter #(.IFG_CYCLES(12), .MAX_FRAME_LEN(8)) dut1 (
        .clk(clk), .reset(reset), .arp_axis(a1), .udp_axis(u1), .mac_axis(m1),
        .grant_out(g1), .trunc_err_out(t1));
    tx_arbiter #(.IFG_CYCLES(0), .MAX_FRAME_LEN(1514)) dut2 (
        .clk(clk), .reset(reset), .arp_axis(a2), .udp_axis(u2), .mac_axis(m2),
        .grant_out(g2), .trunc_err_out(t2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [7:0] dat;
        logic       v, l, r, tr;
        logic [1:0] g;
        logic       ar, ur, av, uv;
    } mon_t;

    int         max_len [3] = '{1514, 8, 1514};
    logic [9:0] exp_q   [6][$];   // {trunc, tlast, tdata} per source
    int         end_log [3][$];   // owner (0 ARP, 1 UDP) of each completed frame
    int         gap_log [3][$];   // cycles from last beat of a frame to first beat of the next
    int         hs_cnt  [3];
    int         trunc_cnt [3];
    logic       in_frame [3];
    logic       have_end [3];
    logic       own [3];
    int         end_cyc [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mon_t mon_sample(input int d);
        mon_t m;
        case (d)
            0: m = {m0.tdata, m0.tvalid, m0.tlast, m0.tready, t0, g0, a0.tready, u0.tready, a0.tvalid, u0.tvalid};
            1: m = {m1.tdata, m1.tvalid, m1.tlast, m1.tready, t1, g1, a1.tready, u1.tready, a1.tvalid, u1.tvalid};
            default: m = {m2.tdata, m2.tvalid, m2.tlast, m2.tready, t2, g2, a2.tready, u2.tready, a2.tvalid, u2.tvalid};
        endcase
        return m;
    endfunction

    task automatic drive(input int s, input logic [7:0] d, input logic l, input logic v);
        case (s)
            0: begin a0.tdata = d; a0.tlast = l; a0.tvalid = v; end
            1: begin u0.tdata = d; u0.tlast = l; u0.tvalid = v; end
            2: begin a1.tdata = d; a1.tlast = l; a1.tvalid = v; end
            3: begin u1.tdata = d; u1.tlast = l; u1.tvalid = v; end
            4: begin a2.tdata = d; a2.tlast = l; a2.tvalid = v; end
            default: begin u2.tdata = d; u2.tlast = l; u2.tvalid = v; end
        endcase
    endtask

    function automatic logic get_rdy(input int s);
        case (s)
            0: return a0.tready;
            1: return u0.tready;
            2: return a1.tready;
            3: return u1.tready;
            4: return a2.tready;
            default: return u2.tready;
        endcase
    endfunction

    // Drives a frame beat by beat; stop >= 0 returns with that beat on the bus, unaccepted.
    task automatic send_frame(input int s, input int base, input int len, input int stop);
        int   mx;
        int   waitc;
        logic hs;
        logic [7:0] dat;
        mx = max_len[s / 2];
        for (int i = 0; i < len; i++) begin
            dat = 8'(base + i);
            drive(s, dat, i == len - 1, 1'b1);
            if (i < mx)
                exp_q[s].push_back({(i == mx - 1) && (i != len - 1), (i == len - 1) || (i == mx - 1), dat});
            if (i == stop) return;
            waitc = 0;
            hs    = 1'b0;
            while (!hs && waitc < 2000) begin
                @(negedge clk);
                hs = get_rdy(s);
                @(posedge clk);
                #1;
                waitc++;
            end
            if (!hs) begin
                check("beat_accept_timeout", hs, 1'b1);
                drive(s, 8'h00, 1'b0, 1'b0);
                return;
            end
        end
        drive(s, 8'h00, 1'b0, 1'b0);
    endtask

    // Counts negedges with no grant before a grant appears on instance d.
    task automatic wait_grant(input int d, output int n, output logic [1:0] g);
        mon_t m;
        n = 0;
        g = 2'b00;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            m = mon_sample(d);
            if (m.g != 2'b00) begin
                g = m.g;
                break;
            end
            n++;
        end
        check("grant_seen", g != 2'b00, 1'b1);
    endtask

    mon_t       mm;
    int         ms;
    logic [9:0] me;

    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                in_frame[d] = 1'b0;
                have_end[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                mm = mon_sample(d);
                if (mm.g == 2'b00)      check("idle_quiet", {mm.ar, mm.ur, mm.v}, 3'b000);
                else if (mm.g == 2'b01) check("udp_rdy_blocked", mm.ur, 1'b0);
                else if (mm.g == 2'b10) check("arp_rdy_blocked", mm.ar, 1'b0);
                else                    check("grant_onehot", mm.g, 2'b01);
                if (mm.g != 2'b00 && mm.v)
                    check("src_rdy_mirror", mm.g[1] ? mm.ur : mm.ar, mm.r);
                if (mm.v && mm.r) begin
                    ms = 2 * d + (mm.g[1] ? 1 : 0);
                    hs_cnt[d]++;
                    if (mm.tr) trunc_cnt[d]++;
                    if (in_frame[d]) begin
                        check("grant_held", mm.g[1], own[d]);
                    end else begin
                        if (have_end[d]) gap_log[d].push_back(cyc - end_cyc[d]);
                        in_frame[d] = 1'b1;
                        own[d]      = mm.g[1];
                    end
                    check("beat_expected", exp_q[ms].size() > 0, 1'b1);
                    if (exp_q[ms].size() > 0) begin
                        me = exp_q[ms].pop_front();
                        check("beat", {mm.tr, mm.l, mm.dat}, me);
                    end
                    if (mm.l) begin
                        in_frame[d] = 1'b0;
                        have_end[d] = 1'b1;
                        end_cyc[d]  = cyc;
                        end_log[d].push_back(ms % 2);
                    end
                end else begin
                    check("trunc_without_beat", mm.tr, 1'b0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         h;
        logic [1:0] gg;
        mon_t       r;

        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int d = 0; d < 3; d++) begin
            hs_cnt[d] = 0; trunc_cnt[d] = 0; in_frame[d] = 1'b0;
            have_end[d] = 1'b0; own[d] = 1'b0; end_cyc[d] = 0;
        end
        for (int s = 0; s < 6; s++) drive(s, 8'h00, 1'b0, 1'b0);
        m0.tready = 1'b1; m1.tready = 1'b1; m2.tready = 1'b1;

        // Reset state, with requests pending to show treadys stay low.
        reset = 1'b1;
        drive(0, 8'h5a, 1'b1, 1'b1);
        drive(1, 8'ha5, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        r = mon_sample(0);
        check("rst_grant", r.g, 2'b00);
        check("rst_mac", {r.v, r.l, r.dat}, 10'h000);
        check("rst_rdy", {r.ar, r.ur}, 2'b00);
        check("rst_trunc", r.tr, 1'b0);
        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single 42-beat ARP frame, then the gap before the next frame.
        fork
            send_frame(0, 8'h10, 42, -1);
            wait_grant(0, n, gg);
        join
        check("t1_grant_latency", n, 1);
        check("t1_grant", gg, 2'b01);
        check("t1_beats", hs_cnt[0], 42);
        fork
            send_frame(0, 8'h50, 1, -1);
            wait_grant(0, n, gg);
        join
        check("t1_gap_wait", n, 13);

        // Both sources continuous: last owner was ARP, so UDP takes the first tie.
        end_log[0].delete();
        gap_log[0].delete();
        fork
            begin send_frame(1, 8'h20, 10, -1); send_frame(1, 8'h30, 10, -1); end
            begin send_frame(0, 8'h60, 10, -1); send_frame(0, 8'h70, 10, -1); end
        join
        check("t2_frames", end_log[0].size(), 4);
        for (int k = 0; k < 4 && end_log[0].size() > 0; k++)
            check("t2_owner", end_log[0].pop_front(), (k % 2 == 0) ? 1 : 0);
        check("t2_gaps", gap_log[0].size(), 4);
        while (gap_log[0].size() > 0) check("t2_gap_len", gap_log[0].pop_front(), 14);

        // UDP 20-beat frame under alternating MAC backpressure.
        h = hs_cnt[0];
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    @(posedge clk); #1;
                    m0.tready = ~m0.tready;
                end
                m0.tready = 1'b1;
            end
            send_frame(1, 8'h90, 20, -1);
        join
        check("t3_handshakes", hs_cnt[0] - h, 20);

        // Cap of 8 beats: a 12-beat ARP frame is cut, the tail dropped, then the gap.
        send_frame(2, 8'ha0, 12, -1);
        check("t4_beats", hs_cnt[1], 8);
        check("t4_trunc_pulses", trunc_cnt[1], 1);
        fork
            send_frame(2, 8'hb0, 1, -1);
            wait_grant(1, n, gg);
        join
        check("t4_gap_wait", n, 13);

        // No gap: back-to-back 1-beat UDP frames land every 2 cycles.
        gap_log[2].delete();
        for (int k = 0; k < 4; k++) send_frame(5, 8'hc0 + k, 1, -1);
        check("t5_gaps", gap_log[2].size(), 3);
        while (gap_log[2].size() > 0) check("t5_gap_len", gap_log[2].pop_front(), 2);
        check("t5_beats", hs_cnt[2], 4);

        // Reset with beat 5 of a UDP frame on the bus.
        send_frame(1, 8'he0, 10, 4);
        #1 reset = 1'b1;
        #1;
        r = mon_sample(0);
        check("rstmid_grant", r.g, 2'b00);
        check("rstmid_mac", {r.v, r.l, r.dat}, 10'h000);
        check("rstmid_rdy", r.ur, 1'b0);
        exp_q[1].delete();
        drive(1, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        end_log[0].delete();
        end_log[1].delete();
        send_frame(1, 8'he0, 10, -1);
        check("rstmid_restart_owner", end_log[0].size() > 0 ? end_log[0].pop_front() : -1, 1);
        fork
            send_frame(0, 8'h01, 3, -1);
            send_frame(1, 8'h11, 3, -1);
            send_frame(2, 8'h21, 3, -1);
            send_frame(3, 8'h31, 3, -1);
        join
        check("tie0_first", end_log[0].size() > 0 ? end_log[0].pop_front() : -1, 0);
        check("tie0_second", end_log[0].size() > 0 ? end_log[0].pop_front() : -1, 1);
        check("tie1_first", end_log[1].size() > 0 ? end_log[1].pop_front() : -1, 0);
        check("tie1_second", end_log[1].size() > 0 ? end_log[1].pop_front() : -1, 1);

        repeat (2) @(posedge clk);
        for (int s = 0; s < 6; s++) check("sb_drained", exp_q[s].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
